// File: rtl/uart_loader_pkg.sv
// Shared constants and state encoding for the serial boot loader.
package uart_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CNT_H,
        ST_CNT_L,
        ST_ADR_H,
        ST_ADR_L,
        ST_DAT_H,
        ST_DAT_L,
        ST_CSUM,
        ST_RESP,
        ST_RUN
    } state_e;

endpackage

// File: rtl/uart_loader.sv
// Serial boot loader: receives a framed program image over the UART byte
// stream, writes it into program RAM, answers ACK/NAK and releases the CPU.
module uart_loader #(
    parameter int unsigned MEM_WORDS      = 4096,
    parameter int unsigned TIMEOUT_CYCLES = 48_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_rd,
    input  logic        tx_busy,
    output logic        tx_wr,
    output logic [7:0]  tx_data,
    output logic        mem_write_enable,
    output logic [0:15] mem_write_addr,
    output logic [0:15] mem_write_data,
    output logic        cpu_run,
    output logic        busy,
    output logic        error
);
    import uart_loader_pkg::*;

    localparam int unsigned   TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);
    localparam logic [16:0]   MEM_LIMIT = 17'(MEM_WORDS);

    state_e        state_q, state_d;
    logic [1:0]    hold_q, hold_d;
    logic          rx_rd_q, rx_rd_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   adr_q, adr_d;
    logic [7:0]    hi_q, hi_d;
    logic [7:0]    sum_q, sum_d;
    logic          range_err_q, range_err_d;
    logic          nak_q, nak_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          we_q, we_d;
    logic [0:15]   wa_q, wa_d;
    logic [0:15]   wd_q, wd_d;
    logic          run_q, run_d;
    logic          error_q, error_d;

    logic          expect_byte;
    logic          timed;
    logic          accept;
    logic          send;
    logic [16:0]   end_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            rx_rd_q     <= 1'b0;
            cnt_q       <= '0;
            adr_q       <= '0;
            hi_q        <= '0;
            sum_q       <= '0;
            range_err_q <= 1'b0;
            nak_q       <= 1'b0;
            tmo_q       <= '0;
            tx_data_q   <= '0;
            we_q        <= 1'b0;
            wa_q        <= '0;
            wd_q        <= '0;
            run_q       <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            rx_rd_q     <= rx_rd_d;
            cnt_q       <= cnt_d;
            adr_q       <= adr_d;
            hi_q        <= hi_d;
            sum_q       <= sum_d;
            range_err_q <= range_err_d;
            nak_q       <= nak_d;
            tmo_q       <= tmo_d;
            tx_data_q   <= tx_data_d;
            we_q        <= we_d;
            wa_q        <= wa_d;
            wd_q        <= wd_d;
            run_q       <= run_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        adr_d       = adr_q;
        hi_d        = hi_q;
        sum_d       = sum_q;
        range_err_d = range_err_q;
        nak_d       = nak_q;
        tx_data_d   = tx_data_q;
        we_d        = 1'b0;
        wa_d        = wa_q;
        wd_d        = wd_q;
        run_d       = run_q;
        error_d     = error_q;

        expect_byte = state_q inside {ST_IDLE, ST_CNT_H, ST_CNT_L, ST_ADR_H,
                                      ST_ADR_L, ST_DAT_H, ST_DAT_L, ST_CSUM};
        timed       = expect_byte && (state_q != ST_IDLE);
        // hold_q masks rx_valid for the rx_rd cycle and the one after it
        accept      = rx_valid && (hold_q == 2'd0) && expect_byte;
        send        = (state_q == ST_RESP) && !tx_busy && !reset;
        end_addr    = {1'b0, adr_q[15:8], rx_data} + {1'b0, cnt_q};

        rx_rd_d = accept;
        hold_d  = accept ? 2'd2 : ((hold_q == 2'd0) ? 2'd0 : hold_q - 2'd1);
        tmo_d   = '0;
        if (timed) begin
            tmo_d = accept ? TW'(1) : tmo_q + TW'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (accept && rx_data == SYNC_BYTE) begin
                    error_d     = 1'b0;
                    sum_d       = '0;
                    cnt_d       = '0;
                    range_err_d = 1'b0;
                    nak_d       = 1'b0;
                    state_d     = ST_CNT_H;
                end
            end
            ST_CNT_H: if (accept) begin
                cnt_d[15:8] = rx_data;
                state_d     = ST_CNT_L;
            end
            ST_CNT_L: if (accept) begin
                cnt_d[7:0] = rx_data;
                state_d    = ST_ADR_H;
            end
            ST_ADR_H: if (accept) begin
                adr_d[15:8] = rx_data;
                state_d     = ST_ADR_L;
            end
            ST_ADR_L: if (accept) begin
                adr_d[7:0]  = rx_data;
                range_err_d = end_addr > MEM_LIMIT;
                state_d     = (cnt_q == 16'd0) ? ST_CSUM : ST_DAT_H;
            end
            ST_DAT_H: if (accept) begin
                hi_d    = rx_data;
                sum_d   = sum_q + rx_data;
                state_d = ST_DAT_L;
            end
            ST_DAT_L: if (accept) begin
                sum_d = sum_q + rx_data;
                if (!range_err_q) begin
                    we_d = 1'b1;
                    wa_d = adr_q;
                    wd_d = {hi_q, rx_data};
                end
                adr_d   = adr_q + 16'd1;
                cnt_d   = cnt_q - 16'd1;
                state_d = (cnt_q == 16'd1) ? ST_CSUM : ST_DAT_H;
            end
            ST_CSUM: if (accept) begin
                nak_d     = (rx_data != sum_q) || range_err_q;
                tx_data_d = nak_d ? NAK_BYTE : ACK_BYTE;
                state_d   = ST_RESP;
            end
            ST_RESP: if (send) begin
                if (nak_q) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    run_d   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: ;
            default: state_d = ST_IDLE;
        endcase

        if (timed && !accept && tmo_q == TMO_LIMIT) begin
            nak_d     = 1'b1;
            tx_data_d = NAK_BYTE;
            state_d   = ST_RESP;
        end
    end

    assign rx_rd            = rx_rd_q;
    assign tx_wr            = send;
    assign tx_data          = tx_data_q;
    assign mem_write_enable = we_q;
    assign mem_write_addr   = wa_q;
    assign mem_write_data   = wd_q;
    // cpu_run must rise together with the ACK strobe, hence the combinational term
    assign cpu_run          = run_q | (send & ~nak_q);
    assign busy             = timed || (state_q == ST_RESP);
    assign error            = error_q;

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: directed frames plus random frames
// checked against a frame-level reference model.
module tb_uart_loader;

    localparam int unsigned MEM  = 4096;
    localparam int unsigned TMO  = 100;
    localparam logic [7:0]  SYNC = 8'hA5;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_rd;
    logic        tx_busy;
    logic        tx_wr;
    logic [7:0]  tx_data;
    logic        mem_write_enable;
    logic [0:15] mem_write_addr;
    logic [0:15] mem_write_data;
    logic        cpu_run;
    logic        busy;
    logic        error;

    uart_loader #(
        .MEM_WORDS      (MEM),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .rx_valid         (rx_valid),
        .rx_data          (rx_data),
        .rx_rd            (rx_rd),
        .tx_busy          (tx_busy),
        .tx_wr            (tx_wr),
        .tx_data          (tx_data),
        .mem_write_enable (mem_write_enable),
        .mem_write_addr   (mem_write_addr),
        .mem_write_data   (mem_write_data),
        .cpu_run          (cpu_run),
        .busy             (busy),
        .error            (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation log, sampled mid-cycle
    logic [31:0] wr_q[$];
    logic [7:0]  tx_q[$];
    logic        tx_run_q[$];
    int unsigned tx_cyc  = 0;
    int unsigned rd_cnt  = 0;
    int unsigned rd_last = 0;

    always @(negedge clk) begin
        if (mem_write_enable) wr_q.push_back({mem_write_addr, mem_write_data});
        if (tx_wr) begin
            tx_q.push_back(tx_data);
            tx_run_q.push_back(cpu_run);
            tx_cyc = cyc;
        end
        if (rx_rd) begin
            rd_cnt++;
            rd_last = cyc;
        end
    end

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [7:0]  frame_q[$];
    logic [31:0] exp_wr[$];
    logic [7:0]  exp_resp;
    logic        exp_ok;

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic drive_byte(input logic [7:0] b);
        int unsigned w  = 0;
        int unsigned n0 = rd_cnt;
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = b;
        while (rd_cnt == n0 && w < 40) begin @(negedge clk); w++; end
        total++;
        if (rd_cnt == n0) begin
            $display("FAIL rx_rd_wait: byte %02h got no rx_rd in %0d cycles, want one", b, w);
            bad++;
        end
        @(posedge clk); #1 rx_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    task automatic send_frame();
        foreach (frame_q[i]) drive_byte(frame_q[i]);
    endtask

    task automatic wait_tx(input int unsigned n0, input int unsigned limit);
        int unsigned w = 0;
        while (tx_q.size() == n0 && w < limit) begin @(negedge clk); w++; end
        total++;
        if (tx_q.size() == n0) begin
            $display("FAIL tx_wait: got no tx_wr in %0d cycles, want a response", w);
            bad++;
        end
    endtask

    // Reference: parse the frame by its rules, not by replaying a state machine
    task automatic model_frame();
        int unsigned p = 0;
        int unsigned n, a;
        int unsigned s = 0;
        logic [7:0] h, l;
        exp_wr.delete();
        while (frame_q[p] != SYNC) p++;
        n = 32'({frame_q[p+1], frame_q[p+2]});
        a = 32'({frame_q[p+3], frame_q[p+4]});
        for (int unsigned i = 0; i < n; i++) begin
            h = frame_q[p+5+2*i];
            l = frame_q[p+6+2*i];
            s += 32'(h) + 32'(l);
            if (a + n <= MEM) exp_wr.push_back({16'(a + i), h, l});
        end
        exp_ok   = (a + n <= MEM) && (frame_q[p+5+2*n] == 8'(s));
        exp_resp = exp_ok ? 8'h06 : 8'h15;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        reset = 1'b1; rx_valid = 1'b1; rx_data = SYNC; tx_busy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({rx_rd, tx_wr, mem_write_enable, cpu_run, busy, error} !== 6'b0) begin
            $display("FAIL reset_flags: got %b want 000000",
                     {rx_rd, tx_wr, mem_write_enable, cpu_run, busy, error});
            bad++;
        end
        total++;
        if (tx_data !== 8'h00) begin
            $display("FAIL reset_tx_data: got %02h want 00", tx_data); bad++;
        end
        total++;
        if ({mem_write_addr, mem_write_data} !== 32'h0) begin
            $display("FAIL reset_mem_bus: got %h want 0", {mem_write_addr, mem_write_data}); bad++;
        end
        @(posedge clk); #1;
        reset = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic test_ack();
        int unsigned w0, t0;
        do_reset();
        w0 = wr_q.size(); t0 = tx_q.size();
        frame_q = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h10, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
        send_frame();
        wait_tx(t0, 50);
        repeat (3) @(negedge clk);
        total++;
        if (wr_q.size() != w0 + 2) begin
            $display("FAIL ack_wr_count: got %0d want 2", wr_q.size() - w0); bad++;
        end else begin
            total++;
            if (wr_q[w0] !== 32'h0010_1234) begin
                $display("FAIL ack_wr0: got %h want 00101234", wr_q[w0]); bad++;
            end
            total++;
            if (wr_q[w0+1] !== 32'h0011_ABCD) begin
                $display("FAIL ack_wr1: got %h want 0011abcd", wr_q[w0+1]); bad++;
            end
        end
        if (tx_q.size() > t0) begin
            total++;
            if (tx_q[t0] !== 8'h06) begin
                $display("FAIL ack_byte: got %02h want 06", tx_q[t0]); bad++;
            end
            total++;
            if (tx_run_q[t0] !== 1'b1) begin
                $display("FAIL ack_run_with_txwr: got %b want 1", tx_run_q[t0]); bad++;
            end
        end
        total++;
        if ({cpu_run, error, busy} !== 3'b100) begin
            $display("FAIL ack_status: got run/err/busy=%b want 100", {cpu_run, error, busy}); bad++;
        end
    endtask

    task automatic test_nak_recover();
        int unsigned w0, t0;
        do_reset();
        w0 = wr_q.size(); t0 = tx_q.size();
        frame_q = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h10, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h15};
        send_frame();
        wait_tx(t0, 50);
        repeat (3) @(negedge clk);
        total++;
        if (wr_q.size() != w0 + 2) begin
            $display("FAIL nak_wr_count: got %0d want 2", wr_q.size() - w0); bad++;
        end
        if (tx_q.size() > t0) begin
            total++;
            if (tx_q[t0] !== 8'h15) begin
                $display("FAIL nak_byte: got %02h want 15", tx_q[t0]); bad++;
            end
        end
        total++;
        if ({cpu_run, error, busy} !== 3'b010) begin
            $display("FAIL nak_status: got run/err/busy=%b want 010", {cpu_run, error, busy}); bad++;
        end
        w0 = wr_q.size(); t0 = tx_q.size();
        frame_q = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h20, 8'h55, 8'h66, 8'hBB};
        drive_byte(frame_q[0]);
        repeat (2) @(negedge clk);
        total++;
        if (error !== 1'b0) begin
            $display("FAIL sync_clears_error: got %b want 0", error); bad++;
        end
        frame_q.pop_front();
        send_frame();
        wait_tx(t0, 50);
        repeat (3) @(negedge clk);
        total++;
        if (wr_q.size() != w0 + 1 || wr_q[w0] !== 32'h0020_5566) begin
            $display("FAIL recover_wr: got count %0d want 1 at 00205566", wr_q.size() - w0); bad++;
        end
        total++;
        if (tx_q.size() <= t0 || tx_q[t0] !== 8'h06 || cpu_run !== 1'b1) begin
            $display("FAIL recover_ack: got run=%b want ACK and run=1", cpu_run); bad++;
        end
    endtask

    task automatic test_range();
        int unsigned w0, t0;
        do_reset();
        w0 = wr_q.size(); t0 = tx_q.size();
        frame_q = '{8'hA5, 8'h00, 8'h02, 8'h0F, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h02, 8'h03};
        send_frame();
        wait_tx(t0, 50);
        repeat (3) @(negedge clk);
        total++;
        if (wr_q.size() != w0) begin
            $display("FAIL range_no_writes: got %0d writes want 0", wr_q.size() - w0); bad++;
        end
        total++;
        if (tx_q.size() <= t0 || tx_q[t0] !== 8'h15) begin
            $display("FAIL range_nak: got %0d responses want one 15", tx_q.size() - t0); bad++;
        end
        total++;
        if ({cpu_run, error} !== 2'b01) begin
            $display("FAIL range_status: got run/err=%b want 01", {cpu_run, error}); bad++;
        end
    endtask

    task automatic test_resync_zero_len();
        int unsigned w0, t0;
        do_reset();
        w0 = wr_q.size(); t0 = tx_q.size();
        frame_q = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame();
        wait_tx(t0, 50);
        repeat (3) @(negedge clk);
        total++;
        if (wr_q.size() != w0) begin
            $display("FAIL zero_len_writes: got %0d want 0", wr_q.size() - w0); bad++;
        end
        total++;
        if (tx_q.size() <= t0 || tx_q[t0] !== 8'h06 || cpu_run !== 1'b1) begin
            $display("FAIL zero_len_ack: got run=%b want ACK and run=1", cpu_run); bad++;
        end
    endtask

    task automatic test_timeout();
        int unsigned t0;
        do_reset();
        t0 = tx_q.size();
        frame_q = '{8'hA5, 8'h00, 8'h01};
        send_frame();
        wait_tx(t0, 300);
        repeat (3) @(negedge clk);
        total++;
        if (tx_q.size() <= t0 || tx_q[t0] !== 8'h15) begin
            $display("FAIL timeout_nak: got %0d responses want one 15", tx_q.size() - t0); bad++;
        end
        total++;
        if (tx_cyc - rd_last != TMO) begin
            $display("FAIL timeout_delay: got %0d cycles want %0d", tx_cyc - rd_last, TMO); bad++;
        end
        total++;
        if ({busy, error, cpu_run} !== 3'b010) begin
            $display("FAIL timeout_status: got busy/err/run=%b want 010", {busy, error, cpu_run}); bad++;
        end
    endtask

    task automatic test_reset_abort();
        int unsigned t0;
        do_reset();
        t0 = tx_q.size();
        frame_q = '{8'hA5, 8'h00, 8'h01};
        send_frame();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (TMO + 30) @(negedge clk);
        total++;
        if (tx_q.size() != t0 || busy !== 1'b0) begin
            $display("FAIL reset_abort: got %0d responses busy=%b want 0 and 0", tx_q.size() - t0, busy); bad++;
        end
    endtask

    task automatic test_back_to_back_busy();
        int unsigned w0, t0, r0, fall;
        int unsigned s = 0;
        logic [7:0] d;
        do_reset();
        tx_busy = 1'b1;
        w0 = wr_q.size(); t0 = tx_q.size();
        frame_q = '{8'hA5, 8'h00, 8'h03, 8'h01, 8'h00};
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            frame_q.push_back(d);
            s += 32'(d);
        end
        frame_q.push_back(8'(s));
        model_frame();
        send_frame();
        repeat (50) @(posedge clk);
        total++;
        if (tx_q.size() != t0) begin
            $display("FAIL busy_holds_tx: got %0d responses want 0", tx_q.size() - t0); bad++;
        end
        #1 tx_busy = 1'b0;
        fall = cyc;
        wait_tx(t0, 20);
        repeat (5) @(negedge clk);
        total++;
        if (tx_q.size() != t0 + 1) begin
            $display("FAIL single_txwr: got %0d pulses want 1", tx_q.size() - t0); bad++;
        end
        total++;
        if (tx_cyc != fall) begin
            $display("FAIL txwr_on_fall: got cycle %0d want %0d", tx_cyc, fall); bad++;
        end
        total++;
        if (tx_q.size() <= t0 || tx_q[t0] !== exp_resp || cpu_run !== 1'b1) begin
            $display("FAIL busy_frame_ack: got run=%b want ACK %02h and run=1", cpu_run, exp_resp); bad++;
        end
        total++;
        if (wr_q.size() != w0 + exp_wr.size()) begin
            $display("FAIL busy_frame_writes: got %0d want %0d", wr_q.size() - w0, exp_wr.size()); bad++;
        end else begin
            foreach (exp_wr[i]) begin
                total++;
                if (wr_q[w0+i] !== exp_wr[i]) begin
                    $display("FAIL busy_frame_wr%0d: got %h want %h", i, wr_q[w0+i], exp_wr[i]); bad++;
                end
            end
        end
        r0 = rd_cnt;
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = SYNC;
        repeat (20) @(posedge clk);
        #1 rx_valid = 1'b0;
        @(negedge clk);
        total++;
        if (rd_cnt != r0 || tx_q.size() != t0 + 1) begin
            $display("FAIL run_ignores_rx: got %0d rx_rd %0d tx want 0 0", rd_cnt - r0, tx_q.size() - t0 - 1); bad++;
        end
    endtask

    task automatic test_random_frames();
        int unsigned n, a, s, w0, t0;
        logic [7:0] d, cs;
        for (int it = 0; it < 10; it++) begin
            do_reset();
            frame_q.delete();
            if ($urandom_range(0, 3) == 0) frame_q.push_back(8'($urandom_range(0, 8'hA4)));
            n = $urandom_range(0, 5);
            a = ($urandom_range(0, 2) == 0) ? (MEM - n + $urandom_range(0, 2))
                                            : $urandom_range(0, MEM - 8);
            frame_q.push_back(SYNC);
            frame_q.push_back(8'(n >> 8));
            frame_q.push_back(8'(n));
            frame_q.push_back(8'(a >> 8));
            frame_q.push_back(8'(a));
            s = 0;
            for (int unsigned i = 0; i < 2 * n; i++) begin
                d = 8'($urandom);
                frame_q.push_back(d);
                s += 32'(d);
            end
            cs = 8'(s);
            if ($urandom_range(0, 3) == 0) cs = cs + 8'd1;
            frame_q.push_back(cs);
            model_frame();
            w0 = wr_q.size(); t0 = tx_q.size();
            send_frame();
            wait_tx(t0, 50);
            repeat (3) @(negedge clk);
            total++;
            if (tx_q.size() <= t0 || tx_q[t0] !== exp_resp || tx_run_q[t0] !== exp_ok) begin
                $display("FAIL rand%0d_resp: got %0d responses want one %02h run=%b", it, tx_q.size() - t0, exp_resp, exp_ok); bad++;
            end
            total++;
            if ({cpu_run, error} !== {exp_ok, !exp_ok}) begin
                $display("FAIL rand%0d_status: got run/err=%b want %b", it, {cpu_run, error}, {exp_ok, !exp_ok}); bad++;
            end
            total++;
            if (wr_q.size() != w0 + exp_wr.size()) begin
                $display("FAIL rand%0d_wr_count: got %0d want %0d", it, wr_q.size() - w0, exp_wr.size()); bad++;
            end else begin
                foreach (exp_wr[i]) begin
                    total++;
                    if (wr_q[w0+i] !== exp_wr[i]) begin
                        $display("FAIL rand%0d_wr%0d: got %h want %h", it, i, wr_q[w0+i], exp_wr[i]); bad++;
                    end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
        test_reset();
        test_ack();
        test_nak_recover();
        test_range();
        test_resync_zero_len();
        test_timeout();
        test_reset_abort();
        test_back_to_back_busy();
        test_random_frames();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
